// File: rtl/add_slice_sequencer_pkg.sv
// Shared types and defaults for the slice-serial adder (package addseq_pkg).
package addseq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W_DEF = 32;
    localparam int S_DEF = 8;

    function automatic int nslice(input int w, input int s);
        return w / s;
    endfunction
endpackage

// File: rtl/add_slice_sequencer_slice.sv
// S-bit ripple adder slice; also exposes the carry into its MSB for overflow detection.
module slice_adder #(
    parameter int S = 8
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] s,
    output logic         cout,
    output logic         cmsb
);
    logic [S-1:0] lo;
    logic [1:0]   hi;

    // Low S-1 bits first so the carry into the MSB is visible on its own.
    assign lo   = {1'b0, a[S-2:0]} + {1'b0, b[S-2:0]} + S'(cin);
    assign hi   = {1'b0, a[S-1]} + {1'b0, b[S-1]} + {1'b0, lo[S-1]};
    assign s    = {hi[0], lo[S-2:0]};
    assign cout = hi[1];
    assign cmsb = lo[S-1];
endmodule

// File: rtl/add_slice_sequencer.sv
// W-bit adder that time-shares one S-bit slice, LSB slice first.
// Optional subtract path enabled by defining ADDSEQ_SUB_EN.
module add_slice_sequencer
    import addseq_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int S = S_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] R,
    input  logic [W-1:0] T,
    input  logic         Cin,
`ifdef ADDSEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         Cout,
    output logic         OF
);
    localparam int NSLICE = nslice(W, S);
    localparam int CW     = $clog2(NSLICE);

    if ((W % S) != 0 || NSLICE < 2) begin : g_param_chk
        $error("add_slice_sequencer: W must be a multiple of S with W/S >= 2");
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_q, b_q;
    logic          carry_q;
    logic [S-1:0]  sl_sum;
    logic          sl_cout, sl_cmsb;
    logic          accept, last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (cnt == CW'(NSLICE - 1));

    slice_adder #(.S(S)) u_slice (
        .a   (a_q[cnt*S +: S]),
        .b   (b_q[cnt*S +: S]),
        .cin (carry_q),
        .s   (sl_sum),
        .cout(sl_cout),
        .cmsb(sl_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            Cout    <= 1'b0;
            OF      <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            a_q <= R;
`ifdef ADDSEQ_SUB_EN
            // Subtract as R + ~T + 1; caller's Cin is dropped in that case.
            b_q     <= sub ? ~T : T;
            carry_q <= sub ? 1'b1 : Cin;
`else
            b_q     <= T;
            carry_q <= Cin;
`endif
        end else if (state == RUN) begin
            sum[cnt*S +: S] <= sl_sum;
            carry_q         <= sl_cout;
            if (last) begin
                Cout <= sl_cout;
                OF   <= sl_cmsb ^ sl_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add_slice_sequencer.sv
// Directed self-checking bench for add_slice_sequencer with a result scoreboard.
module tb_add_slice_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_ready;
    logic [31:0] R = 0, T = 0;
    logic        Cin = 0, sub = 0;
    logic        out_valid, out_ready = 0;
    logic [31:0] sum;
    logic        Cout, OF;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        of;
    } res_t;

    res_t sb[$];
    int   pass = 0, total = 0, fails = 0;

    always #5 clk = ~clk;

    add_slice_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .R(R), .T(T), .Cin(Cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .Cout(Cout), .OF(OF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] r, input logic [31:0] t,
                                   input logic c, input logic s);
        logic [31:0] tt;
        logic [32:0] full;
        res_t o;
        tt   = s ? ~t : t;
        full = {1'b0, r} + {1'b0, tt} + {32'd0, (s ? 1'b1 : c)};
        o.s  = full[31:0];
        o.co = full[32];
        o.of = (r[31] == tt[31]) && (full[31] != r[31]);
        return o;
    endfunction

    task automatic cmp_out(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, sum, e.s);
        chk({tag, "_cout"}, {31'd0, Cout}, {31'd0, e.co});
        chk({tag, "_of"}, {31'd0, OF}, {31'd0, e.of});
    endtask

    // One transaction: accept, scramble inputs during RUN, stall 'hold' cycles in DONE.
    task automatic run_op(input string tag, input logic [31:0] r, input logic [31:0] t,
                          input logic c, input logic s, input int hold);
        int lat;
        logic [31:0] s0;
        logic co0, of0;
        sb.push_back(model(r, t, c, s));
        @(negedge clk);
        R = r; T = t; Cin = c; sub = s; in_valid = 1; out_ready = 0;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            R = $urandom; T = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        s0 = sum; co0 = Cout; of0 = OF;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_sum"}, sum, s0);
            chk({tag, "_hold_flags"}, {30'd0, Cout, OF}, {30'd0, co0, of0});
            chk({tag, "_hold_busy"}, {30'd0, in_ready, out_valid}, 32'b01);
        end
        cmp_out(tag);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "_to_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int last_acc, k, guard;
        // Reset state
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", {30'd0, Cout, OF}, 32'd0);
        @(negedge clk); rst_n = 1;

        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
        run_op("bp", 32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0, 6);
        run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);

        // Abort mid-RUN: accept, let cnt reach 2, then assert reset.
        @(negedge clk);
        R = 32'hAAAA_AAAA; T = 32'h5555_5555; Cin = 1; sub = 0; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 0; #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", sum, 32'd0);
        chk("abort_flags", {30'd0, Cout, OF}, 32'd0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0);

`ifdef ADDSEQ_SUB_EN
        run_op("sub5m7", 32'd5, 32'd7, 1'b0, 1'b1, 0);
        run_op("subovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 0);
`endif

        // Back-to-back: in_valid and out_ready both held high.
        last_acc = -1;
        @(negedge clk);
        in_valid = 1; out_ready = 1; sub = 0;
        R = $urandom; T = $urandom; Cin = 1'($urandom);
        for (k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) cmp_out("b2b");
            if (in_ready) begin
                sb.push_back(model(R, T, Cin, 1'b0));
                if (last_acc >= 0) chk("b2b_spacing", k - last_acc, 6);
                last_acc = k;
            end
            @(posedge clk); #1;
            R = $urandom; T = $urandom; Cin = 1'($urandom);
        end
        in_valid = 0;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            if (out_valid) cmp_out("b2b_drain");
            guard++;
        end
        chk("b2b_drained", sb.size(), 0);
        out_ready = 0;

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/add_slice_sequencer.md
# add_slice_sequencer

Multi-cycle 32-bit adder controller that time-shares one 8-bit adder slice across the operand width. Accepts an operand pair over a valid/ready handshake and feeds one slice per cycle into the slice adder, least-significant slice first. It registers the inter-slice carry and assembles the sum, then presents sum, carry-out and signed overflow on an output valid/ready handshake. It is the area-reduced alternative to the full-width chunked adder in the arithmetic datapath.

## Interface
- `W`, 32: operand/sum width; must be a multiple of `S`
- `S`, 8: slice width; `W/S` ≥ 2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `R`  in  W  operand A
- `T`  in  W  operand B
- `Cin`  in  1  carry-in to slice 0
- `sub`  in  1  subtract request; present only with `ADDSEQ_SUB_EN`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  W  result
- `Cout`  out  1  carry out of MSB slice
- `OF`  out  1  two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch `R`, `T`, `Cin` (and `sub`); slice counter `cnt`←0; carry register←`Cin`; go to RUN.
- RUN: one cycle per slice. Slice adder gets `R[cnt*S +: S]`, `T[cnt*S +: S]` and the carry register. Its sum is written to `sum[cnt*S +: S]`, and its carry-out goes to the carry register. `cnt` increments each cycle.
- RUN end: when `cnt == W/S-1`, capture `Cout` = slice carry-out and `OF` = carry into MSB XOR carry out of MSB. Go to DONE.
- DONE: `out_valid`=1; `sum`/`Cout`/`OF` held stable. On `out_ready`, go to IDLE.
- Boundary rules:
  - Operands and inputs are ignored outside the IDLE accept cycle; mid-operation input changes do not affect the result.
  - No accept in the same cycle as the output handshake.
  - `cnt` never wraps past `W/S-1`.
- Arithmetic: modulo 2^W sum; `Cout` is the unsigned carry.

## Timing
- Reset (async assert, sync-to-clk deassert at the first edge): state IDLE, `cnt`=0, `in_ready`=1, `out_valid`=0, `sum`=0, `Cout`=0, `OF`=0.
- Reset asserted in RUN or DONE aborts the operation immediately; no `out_valid` is produced.
- Latency: accept at edge e0 → `out_valid` high after edge e(W/S) (4 cycles with defaults).
- Minimum initiation interval: W/S+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state; no combinational path from `in_valid`/`out_ready` to outputs.
- `sum` slices update progressively during RUN. Only the value qualified by `out_valid` is defined.

## Configuration
- `ADDSEQ_SUB_EN` defined:
  - `sub` port exists. When `sub`=1 at accept, the block latches ~`T` and forces the slice-0 carry to 1, so it computes R − T.
  - `Cout` = 1 means no borrow.
  - `Cin` is ignored when `sub`=1.
- Macro undefined: no `sub` port; add only.

## Structure
- Package `addseq_pkg` holds:
  - state enum (IDLE/RUN/DONE);
  - default `W`/`S` constants;
  - `NSLICE = W/S` derivation helper.
- Sub-module `slice_adder` (`S`-bit ripple adder with `Cout`, carry-into-MSB output for overflow) is instantiated once.
- Elaboration-time assertion that `W % S == 0` and `W/S ≥ 2`.

## Test plan
- `R`=0xFFFFFFFF, `T`=0x00000001, `Cin`=0 → `sum`=0x00000000, `Cout`=1, `OF`=0; `out_valid` rises 4 cycles after accept.
- `R`=0x7FFFFFFF, `T`=0x00000001 → `sum`=0x80000000, `Cout`=0, `OF`=1. Also `R`=0x12345678, `T`=0x11111111, `Cin`=1 → `sum`=0x2345678A.
- Backpressure: `out_ready`=0 for 6 cycles in DONE → `sum`/`Cout`/`OF` stable and `in_ready`=0 throughout. `out_ready`=1 → IDLE next cycle. `R`/`T` toggled during RUN → result unchanged.
- Reset mid-RUN (after `cnt`=2) → all outputs zero, `in_ready`=1, no `out_valid`. Next op 0x00000003+0x00000004 → 0x00000007.
- Back-to-back `in_valid` held high with `out_ready`=1 → accepts spaced exactly 6 cycles; each result matches the reference model.
- With `ADDSEQ_SUB_EN`: `R`=5, `T`=7, `sub`=1 → `sum`=0xFFFFFFFE, `Cout`=0, `OF`=0. Also `R`=0x80000000, `T`=1, `sub`=1 → `sum`=0x7FFFFFFF, `OF`=1.
